// File: rtl/dhash_stream_if.sv
// Pixel-in / hash-out valid-ready bundle for dhash_stream.
// master = pixel producer and hash consumer, slave = the hasher.
interface dhash_stream_if #(
    parameter int PIX_WIDTH = 8,
    parameter int OUT_WIDTH = 64
);
    logic [PIX_WIDTH-1:0] pix;
    logic                 pix_vld;
    logic                 pix_rdy;
    logic [OUT_WIDTH-1:0] hash;
    logic                 hash_vld;
    logic                 hash_rdy;

    modport master (
        output pix, pix_vld, hash_rdy,
        input  pix_rdy, hash, hash_vld
    );

    modport slave (
        input  pix, pix_vld, hash_rdy,
        output pix_rdy, hash, hash_vld
    );
endinterface

// File: rtl/dhash_stream.sv
// Streaming difference-hash over a raster-order grayscale frame.
// Define DHASH_THRESH_EN to add the thr input (ref - pix > thr).
module dhash_stream #(
    parameter int PIX_WIDTH = 8,
    parameter int COLS      = 8,
    parameter int ROWS      = 8,
    parameter int OUT_WIDTH = ROWS * COLS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 mode,
`ifdef DHASH_THRESH_EN
    input  logic [PIX_WIDTH-1:0] thr,
`endif
    output logic                 busy,
    dhash_stream_if.slave        bus
);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int LW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic                 mode_q;
    logic                 run;
    logic [PIX_WIDTH-1:0] prev;
    logic [PIX_WIDTH-1:0] lbuf [COLS];
    logic [OUT_WIDTH-1:0] acc;

    logic                 first;
    logic                 m;
    logic [CW-1:0]        col_max;
    logic [RW-1:0]        row_max;
    logic                 last;
    logic [LW-1:0]        lidx;
    logic [PIX_WIDTH-1:0] refp;
    logic                 cmp_en;
    logic                 cmp_bit;
    logic                 xfer;

    // Mode is taken live on the first pixel, then from the latch.
    assign first   = !busy;
    assign m       = first ? mode : mode_q;
    assign col_max = m ? CW'(COLS - 1) : CW'(COLS);
    assign row_max = m ? RW'(ROWS) : RW'(ROWS - 1);
    assign last    = (col == col_max) && (row == row_max);
    assign lidx    = col[LW-1:0];
    assign refp    = m ? lbuf[lidx] : prev;
    assign cmp_en  = m ? (row != '0) : (col != '0);

`ifdef DHASH_THRESH_EN
    logic [PIX_WIDTH-1:0] thr_q;
    logic [PIX_WIDTH-1:0] thr_a;
    logic signed [PIX_WIDTH:0] diff;

    assign thr_a   = first ? thr : thr_q;
    assign diff    = $signed({1'b0, refp}) - $signed({1'b0, bus.pix});
    assign cmp_bit = diff > $signed({1'b0, thr_a});
`else
    assign cmp_bit = refp > bus.pix;
`endif

    // Only a frame's last pixel has to wait for the output slot.
    assign bus.pix_rdy = run && !clr &&
                         !(last && bus.hash_vld && !bus.hash_rdy);
    assign xfer = bus.pix_vld && bus.pix_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run          <= 1'b0;
            col          <= '0;
            row          <= '0;
            mode_q       <= 1'b0;
            prev         <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            bus.hash     <= '0;
            bus.hash_vld <= 1'b0;
            for (int i = 0; i < COLS; i++) lbuf[i] <= '0;
        end else begin
            run <= 1'b1;
            if (clr) begin
                col  <= '0;
                row  <= '0;
                acc  <= '0;
                busy <= 1'b0;
            end else if (xfer) begin
                if (first) mode_q <= mode;
                prev <= bus.pix;
                if (m) lbuf[lidx] <= bus.pix;
                if (last) begin
                    col  <= '0;
                    row  <= '0;
                    acc  <= '0;
                    busy <= 1'b0;
                end else begin
                    busy <= 1'b1;
                    if (col == col_max) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (cmp_en) acc <= {acc[OUT_WIDTH-2:0], cmp_bit};
                end
            end

            if (xfer && last) begin
                bus.hash     <= {acc[OUT_WIDTH-2:0], cmp_bit};
                bus.hash_vld <= 1'b1;
            end else if (bus.hash_vld && bus.hash_rdy) begin
                bus.hash_vld <= 1'b0;
            end
        end
    end

`ifdef DHASH_THRESH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= '0;
        end else if (!clr && xfer && first) begin
            thr_q <= thr;
        end
    end
`endif
endmodule

// File: tb/tb_dhash_stream.sv
// Testbench for dhash_stream: directed frames plus random frames
// scored against a frame-level dHash model.
module tb_dhash_stream;
    localparam int PW = 8;
    localparam int C  = 8;
    localparam int R  = 8;
    localparam int OW = R * C;
    localparam int NPIX = (C + 1) * R;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic mode  = 1'b0;
    logic busy;
`ifdef DHASH_THRESH_EN
    logic [PW-1:0] thr = '0;
`endif

    dhash_stream_if #(.PIX_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

    dhash_stream #(
        .PIX_WIDTH(PW),
        .COLS(C),
        .ROWS(R)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .mode(mode),
`ifdef DHASH_THRESH_EN
        .thr(thr),
`endif
        .busy(busy),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int frm [NPIX];
    int thr_v   = 0;
    logic [OW-1:0] exp_q [$];
    bit sb_on    = 1'b0;
    bit rnd_rdy  = 1'b0;
    bit rnd_mode = 1'b0;
    bit gaps     = 1'b0;
    logic [OW-1:0] ones;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // dHash of the stored frame straight from its definition.
    function automatic logic [OW-1:0] model(input bit m, input int t);
        int nc = m ? C : C + 1;
        int nr = m ? R + 1 : R;
        logic [OW-1:0] h = '0;
        int rv;
        int cv;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                cv = frm[r * nc + c];
                if (!m && c > 0) begin
                    rv = frm[r * nc + c - 1];
                    h = {h[OW-2:0], (rv - cv) > t};
                end else if (m && r > 0) begin
                    rv = frm[(r - 1) * nc + c];
                    h = {h[OW-2:0], (rv - cv) > t};
                end
            end
        end
        return h;
    endfunction

    task automatic fill(input bit m, input int kind);
        int nc = m ? C : C + 1;
        int nr = m ? R + 1 : R;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                case (kind)
                    0: frm[r * nc + c] = c * 10;
                    1: frm[r * nc + c] = (nc - 1 - c) * 10;
                    2: frm[r * nc + c] = 50;
                    3: frm[r * nc + c] = 200 - 10 * r;
                    4: frm[r * nc + c] = (c % 2) ? 96 : 100;
                    default: frm[r * nc + c] =
                        $urandom_range(0, 1) ?
                        int'($urandom_range(0, 255)) :
                        int'($urandom_range(60, 62));
                endcase
            end
        end
    endtask

    task automatic send(input bit m, input int lo, input int hi);
        bit got;
        if (lo == 0) begin
            mode = m;
`ifdef DHASH_THRESH_EN
            thr = thr_v[PW-1:0];
`endif
        end
        for (int i = lo; i < hi; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.pix_vld = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.pix     = frm[i][PW-1:0];
            bus.pix_vld = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                got = bus.pix_rdy;
            end
            if (!got) begin
                check("pix_timeout", 0, 1);
                bus.pix_vld = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (i == 0 && rnd_mode) begin
                mode = 1'($urandom_range(0, 1));
`ifdef DHASH_THRESH_EN
                thr = PW'($urandom_range(0, 255));
`endif
            end
        end
        bus.pix_vld = 1'b0;
        if (hi == NPIX && sb_on) exp_q.push_back(model(m, thr_v));
    endtask

    task automatic accept();
        bus.hash_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.hash_rdy = 1'b0;
        check("vld_drop", bus.hash_vld, 0);
    endtask

    always @(negedge clk) begin
        if (sb_on && rst_n && bus.hash_vld && bus.hash_rdy) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else check("rand_hash", bus.hash, exp_q.pop_front());
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            bus.hash_rdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit m;
        ones = '1;
        bus.pix      = '0;
        bus.pix_vld  = 1'b0;
        bus.hash_rdy = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_hash", bus.hash, 0);
        check("rst_vld", bus.hash_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", bus.pix_rdy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", bus.pix_rdy, 1);

        fill(0, 0);
        send(0, 0, NPIX - 1);
        check("busy_mid", busy, 1);
        check("vld_mid", bus.hash_vld, 0);
        send(0, NPIX - 1, NPIX);
        check("ramp_vld", bus.hash_vld, 1);
        check("ramp_hash", bus.hash, 0);
        check("busy_end", busy, 0);
        accept();

        fill(0, 1);
        send(0, 0, NPIX);
        check("dec_hash", bus.hash, ones);
        accept();
        fill(0, 2);
        send(0, 0, NPIX);
        check("flat_hash", bus.hash, 0);
        accept();

        fill(1, 3);
        send(1, 0, NPIX);
        check("vert_hash", bus.hash, ones);
        accept();
        frm[C] = 250;
        send(1, 0, NPIX);
        check("vert_bump", bus.hash, 64'h7FFF_FFFF_FFFF_FFFF);
        accept();

        fill(0, 0);
        send(0, 0, NPIX);
        fill(0, 1);
        send(0, 0, NPIX - 1);
        check("bp_vld", bus.hash_vld, 1);
        check("bp_first", bus.hash, 0);
        bus.pix     = frm[NPIX-1][PW-1:0];
        bus.pix_vld = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_rdy_low", bus.pix_rdy, 0);
            check("bp_stable", bus.hash, 0);
        end
        @(posedge clk);
        #1;
        bus.hash_rdy = 1'b1;
        #1;
        check("bp_comb", bus.pix_rdy, 1);
        @(posedge clk);
        #1;
        bus.hash_rdy = 1'b0;
        bus.pix_vld  = 1'b0;
        check("bp_cont", bus.hash_vld, 1);
        check("bp_second", bus.hash, ones);
        accept();

        fill(0, 1);
        send(0, 0, NPIX);
        fill(0, 0);
        send(0, 0, 30);
        rst_n = 1'b0;
        #1;
        check("abort_hash", bus.hash, 0);
        check("abort_vld", bus.hash_vld, 0);
        check("abort_busy", busy, 0);
        check("abort_rdy", bus.pix_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill(0, 1);
        send(0, 0, NPIX);
        check("abort_next", bus.hash, ones);
        accept();

        send(0, 0, NPIX);
        fill(0, 0);
        send(0, 0, 30);
        check("clr_busy_pre", busy, 1);
        bus.pix     = 8'd7;
        bus.pix_vld = 1'b1;
        clr = 1'b1;
        #1;
        check("clr_rdy", bus.pix_rdy, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.pix_vld = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_keep_vld", bus.hash_vld, 1);
        check("clr_keep_hash", bus.hash, ones);
        accept();
        fill(1, 3);
        send(1, 0, NPIX);
        check("clr_next", bus.hash, ones);
        accept();

`ifdef DHASH_THRESH_EN
        thr_v = 5;
        fill(0, 4);
        send(0, 0, NPIX);
        check("thr5_hash", bus.hash, 0);
        accept();
        thr_v = 3;
        send(0, 0, NPIX);
        check("thr3_hash", bus.hash, 64'hAAAA_AAAA_AAAA_AAAA);
        accept();
        thr_v = 0;
`endif

        sb_on    = 1'b1;
        rnd_rdy  = 1'b1;
        rnd_mode = 1'b1;
        gaps     = 1'b1;
        for (int f = 0; f < 24; f++) begin
            m = 1'($urandom_range(0, 1));
`ifdef DHASH_THRESH_EN
            thr_v = int'($urandom_range(0, 8));
`endif
            fill(m, (f % 5 == 0) ? int'($urandom_range(0, 4)) : 9);
            send(m, 0, NPIX);
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.hash_rdy = 1'b1;
        for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.hash_vld); k++)
            @(posedge clk);
        @(negedge clk);
        check("drain", exp_q.size(), 0);
        sb_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
